// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction field layout and FSM states for the ALU issue path
package alu_pkg;

  localparam logic [2:0] FS_ADD  = 3'b000;
  localparam logic [2:0] FS_SUB  = 3'b001;
  localparam logic [2:0] FS_AND  = 3'b010;
  localparam logic [2:0] FS_OR   = 3'b011;
  localparam logic [2:0] FS_XOR  = 3'b100;
  localparam logic [2:0] FS_SLT  = 3'b101;
  localparam logic [2:0] OP_RSVD = 3'b110;
  localparam logic [2:0] OP_LDI  = 3'b111;

  localparam int OP_LO  = 13;
  localparam int RD_LO  = 10;
  localparam int RA_LO  = 7;
  localparam int RB_LO  = 4;
  localparam int IMM_W  = 10;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [2:0] instr_op(input logic [15:0] instr);
    return instr[OP_LO +: 3];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rd(input logic [15:0] instr);
    return instr[RD_LO +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_ra(input logic [15:0] instr);
    return instr[RA_LO +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rb(input logic [15:0] instr);
    return instr[RB_LO +: REG_AW];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm(input logic [15:0] instr);
    return instr[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file, two async read ports, one sync write port, r0 hardwired to zero
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q;
  logic [NREGS-1:0][DATA_W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
    // r0 is never stored, so it stays zero regardless of write traffic
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - accepts instructions, drives the external ALU and writes its result back
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [2:0]        alu_fs,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err
);

  state_t              state_q, state_d;
  logic [2:0]          alu_fs_q, alu_fs_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   rdata_a, rdata_b;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   imm_sext;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (instr_ra(instr)),
    .raddr_b (instr_rb(instr)),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata)
  );

  assign imm_sext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  always_comb begin
    state_d  = state_q;
    alu_fs_d = alu_fs_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    rf_we    = 1'b0;
    rf_wdata = alu_out;

    unique case (state_q)
      ST_IDLE: begin
        // Operands are captured here, so rd==ra/rb sees the pre-write value
        if (instr_valid) begin
          alu_fs_d = instr_op(instr);
          alu_a_d  = rdata_a;
          alu_b_d  = rdata_b;
          rd_d     = instr_rd(instr);
          imm_d    = instr_imm(instr);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        err_d   = (alu_fs_q == OP_RSVD);
        if (alu_fs_q == OP_LDI) begin
          rf_we    = 1'b1;
          rf_wdata = imm_sext;
          result_d = imm_sext;
          zero_d   = (imm_q == '0);
        end else if (alu_fs_q != OP_RSVD) begin
          rf_we    = 1'b1;
          rf_wdata = alu_out;
          result_d = alu_out;
          zero_d   = alu_zero;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      alu_fs_q <= FS_ADD;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_fs_q <= alu_fs_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign alu_fs      = alu_fs_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench with a per-cycle reference model for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  alu_fs;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        err;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .NREGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_fs      (alu_fs),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .err         (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycles since accept (0 = waiting, 1 = ALU cycle, 2 = completion cycle)
  int          m_since = 0;
  logic [15:0] m_r [8];
  logic [2:0]  m_fs = 3'd0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_result = 16'h0;
  logic        m_zero = 1'b0, m_err = 1'b0;
  logic [2:0]  p_op = 3'd0, p_rd = 3'd0;
  logic [9:0]  p_imm = 10'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sext10(input logic [9:0] v);
    int x;
    x = int'(v);
    if (x >= 512) x = x - 1024;
    return 16'(x);
  endfunction

  task automatic model_edge();
    logic [15:0] val;
    if (rst) begin
      m_since = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_fs = 3'd0; m_a = 16'h0; m_b = 16'h0;
      m_result = 16'h0; m_zero = 1'b0; m_err = 1'b0;
    end else if (m_since == 0) begin
      if (instr_valid) begin
        p_op  = instr[15:13];
        p_rd  = instr[12:10];
        p_imm = instr[9:0];
        m_fs  = p_op;
        m_a   = m_r[instr[9:7]];
        m_b   = m_r[instr[6:4]];
        m_since = 1;
      end
    end else if (m_since == 1) begin
      m_err = (p_op == 3'd6);
      if (p_op != 3'd6) begin
        val = (p_op == 3'd7) ? sext10(p_imm) : alu_out;
        m_zero = (p_op == 3'd7) ? (p_imm == 10'd0) : alu_zero;
        m_result = val;
        if (p_rd != 3'd0) m_r[p_rd] = val;
      end
      m_since = 2;
    end else begin
      m_since = 0;
    end
  endtask

  task automatic compare_outputs();
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, m_since == 0});
    chk("done", {31'd0, done}, {31'd0, m_since == 2});
    chk("alu_fs", {29'd0, alu_fs}, {29'd0, m_fs});
    chk("alu_a", {16'd0, alu_a}, {16'd0, m_a});
    chk("alu_b", {16'd0, alu_b}, {16'd0, m_b});
    chk("result", {16'd0, result}, {16'd0, m_result});
    chk("zero", {31'd0, zero}, {31'd0, m_zero});
    if (m_since == 2) chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 4'h0};
  endfunction

  // Leaves the bench in cycle N+1 of the accepted instruction
  task automatic accept(input logic [15:0] iw, input logic [15:0] sout, input logic szero);
    alu_out  = sout;
    alu_zero = szero;
    for (int i = 0; i < 10 && !instr_ready; i++) tick();
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    instr = iw;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic finish_op();
    tick();
    chk("done_at_n2", {31'd0, done}, 32'd1);
    tick();
  endtask

  int acc, dn;

  initial begin
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    rst = 1'b1; instr = 16'h0; instr_valid = 1'b0; alu_out = 16'h0; alu_zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'h0000);
    chk("rst_fs", {29'd0, alu_fs}, 32'd0);
    tick();

    // LDI r0 then read r0 back through the operand path
    accept({3'b111, 3'd0, 10'h005}, 16'h0, 1'b0);
    finish_op();
    chk("ldi_r0_result", {16'd0, result}, 32'h0005);
    accept(mk(3'b000, 3'd4, 3'd0, 3'd0), 16'h0, 1'b1);
    chk("r0_reads_zero", {16'd0, alu_a}, 32'h0000);
    finish_op();

    accept({3'b111, 3'd1, 10'h1CB}, 16'h0, 1'b0);
    finish_op();
    chk("ldi_r1_result", {16'd0, result}, 32'h01CB);
    chk("ldi_r1_zero", {31'd0, zero}, 32'd0);

    accept({3'b111, 3'd2, 10'h3FF}, 16'h0, 1'b0);
    finish_op();
    chk("ldi_r2_sext", {16'd0, result}, 32'hFFFF);

    accept(mk(3'b011, 3'd3, 3'd1, 3'd2), 16'h0000, 1'b1);
    chk("issue_fs", {29'd0, alu_fs}, 32'd3);
    chk("issue_a", {16'd0, alu_a}, 32'h01CB);
    chk("issue_b", {16'd0, alu_b}, 32'hFFFF);
    finish_op();
    chk("issue_zero", {31'd0, zero}, 32'd1);

    // rd == ra: operand must be the old r1
    accept(mk(3'b000, 3'd1, 3'd1, 3'd0), 16'h0200, 1'b0);
    chk("hazard_a", {16'd0, alu_a}, 32'h01CB);
    chk("hazard_b", {16'd0, alu_b}, 32'h0000);
    finish_op();

    accept(mk(3'b000, 3'd0, 3'd3, 3'd1), 16'h1234, 1'b0);
    chk("r3_value", {16'd0, alu_a}, 32'h0000);
    chk("r1_after_hazard", {16'd0, alu_b}, 32'h0200);
    finish_op();
    chk("r0_write_result", {16'd0, result}, 32'h1234);
    accept(mk(3'b000, 3'd5, 3'd0, 3'd0), 16'h0000, 1'b1);
    chk("r0_still_zero", {16'd0, alu_a}, 32'h0000);
    finish_op();

    accept(mk(3'b110, 3'd2, 3'd1, 3'd1), 16'h5555, 1'b0);
    tick();
    chk("rsvd_done", {31'd0, done}, 32'd1);
    chk("rsvd_err", {31'd0, err}, 32'd1);
    chk("rsvd_result_hold", {16'd0, result}, 32'h0000);
    tick();
    accept(mk(3'b000, 3'd5, 3'd2, 3'd0), 16'h0000, 1'b1);
    chk("rsvd_no_write", {16'd0, alu_a}, 32'hFFFF);
    finish_op();

    // Held valid: accepted only once every three cycles
    acc = 0; dn = 0;
    instr = mk(3'b110, 3'd4, 3'd0, 3'd0);
    instr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (instr_ready) acc++;
      tick();
      if (done) dn++;
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd3);
    chk("b2b_dones", dn, 32'd2);
    tick(); tick();

    // Reset during EXEC aborts the LDI
    accept({3'b111, 3'd6, 10'h0AA}, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_idle", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("abort_no_done2", {31'd0, done}, 32'd0);
    accept(mk(3'b000, 3'd7, 3'd6, 3'd6), 16'h0000, 1'b1);
    chk("abort_rd_unwritten", {16'd0, alu_a}, 32'h0000);
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
